// File: rtl/idi_sink_mc.sv
// idi_sink_mc: multi-channel memory-side IDI endpoint.
//
// NUM_CH requesters share one word-addressed storage array through a
// round-robin arbiter. Each accepted access produces one registered response
// (single-entry slot, backpressured by rsp_ready) carrying read data or a write
// acknowledgement, plus an out-of-range flag. Saturating counters expose the
// number of successful writes, successful reads and errored accesses.
//
// Ports:
//   clk, rst       clock (rising edge), synchronous active-high reset
//   req_valid      per-channel request valid
//   req_ready      per-channel accept strobe (combinational, at most one bit)
//   req_is_write   per-channel 1 = write, 0 = read
//   req_addr       per-channel byte address, channel i at [i*ADDR_W +: ADDR_W]
//   req_wdata      per-channel write data, channel i at [i*DATA_W +: DATA_W]
//   rsp_valid      response valid
//   rsp_ready      response consumer ready
//   rsp_ch         channel the response belongs to
//   rsp_is_write   response is a write acknowledgement
//   rsp_rdata      read data (0 for writes and errors)
//   rsp_err        address out of range
//   wr_cnt         successful writes, saturating
//   rd_cnt         successful reads, saturating
//   err_cnt        errored accesses, saturating
module idi_sink_mc #(
    parameter int unsigned NUM_CH = 2,
    parameter int unsigned ADDR_W = 64,
    parameter int unsigned DATA_W = 32,
    parameter int unsigned DEPTH  = 16,
    parameter int unsigned CNT_W  = 16,
    localparam int unsigned CH_W  = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic [NUM_CH-1:0]        req_valid,
    output logic [NUM_CH-1:0]        req_ready,
    input  logic [NUM_CH-1:0]        req_is_write,
    input  logic [NUM_CH*ADDR_W-1:0] req_addr,
    input  logic [NUM_CH*DATA_W-1:0] req_wdata,
    output logic                     rsp_valid,
    input  logic                     rsp_ready,
    output logic [CH_W-1:0]          rsp_ch,
    output logic                     rsp_is_write,
    output logic [DATA_W-1:0]        rsp_rdata,
    output logic                     rsp_err,
    output logic [CNT_W-1:0]         wr_cnt,
    output logic [CNT_W-1:0]         rd_cnt,
    output logic [CNT_W-1:0]         err_cnt
);

    localparam int unsigned OFF = $clog2(DATA_W / 8);
    localparam int unsigned IDX = $clog2(DEPTH);

    logic [DATA_W-1:0] mem [DEPTH];
    logic [CH_W-1:0]   ptr;

    logic              slot_free;
    logic              grant_found;
    logic              grant;
    logic [CH_W-1:0]   grant_ch;
    logic [ADDR_W-1:0] sel_addr;
    logic [ADDR_W-1:0] word_addr;
    logic [IDX-1:0]    idx;
    logic              addr_err;
    logic              sel_write;
    logic [DATA_W-1:0] sel_wdata;

    // (base + off) mod NUM_CH; off never exceeds NUM_CH so one subtraction suffices.
    function automatic logic [CH_W-1:0] rot(input logic [CH_W-1:0] base, input int unsigned off);
        int unsigned s;
        s = 32'(base) + off;
        if (s >= NUM_CH) s = s - NUM_CH;
        return CH_W'(s);
    endfunction

    assign slot_free = !rsp_valid || rsp_ready;

    // Round-robin scan starting at ptr.
    always_comb begin
        grant_found = 1'b0;
        grant_ch    = '0;
        for (int unsigned k = 0; k < NUM_CH; k++) begin
            if (!grant_found && req_valid[rot(ptr, k)]) begin
                grant_found = 1'b1;
                grant_ch    = rot(ptr, k);
            end
        end
    end

    assign grant = grant_found && slot_free && !rst;

    always_comb begin
        req_ready = '0;
        if (grant) req_ready[grant_ch] = 1'b1;
    end

    // Decode of the granted channel's request.
    assign sel_addr  = req_addr[32'(grant_ch) * ADDR_W +: ADDR_W];
    assign sel_wdata = req_wdata[32'(grant_ch) * DATA_W +: DATA_W];
    assign sel_write = req_is_write[grant_ch];
    assign word_addr = sel_addr >> OFF;
    assign idx       = word_addr[IDX-1:0];
    assign addr_err  = |(word_addr >> IDX);

    always_ff @(posedge clk) begin
        if (rst) begin
            ptr          <= '0;
            rsp_valid    <= 1'b0;
            rsp_ch       <= '0;
            rsp_is_write <= 1'b0;
            rsp_rdata    <= '0;
            rsp_err      <= 1'b0;
            wr_cnt       <= '0;
            rd_cnt       <= '0;
            err_cnt      <= '0;
            for (int unsigned i = 0; i < DEPTH; i++) mem[i] <= '0;
        end else if (grant) begin
            ptr          <= rot(grant_ch, 1);
            rsp_valid    <= 1'b1;
            rsp_ch       <= grant_ch;
            rsp_is_write <= sel_write;
            rsp_err      <= addr_err;
            rsp_rdata    <= '0;
            if (addr_err) begin
                if (err_cnt != {CNT_W{1'b1}}) err_cnt <= err_cnt + 1'b1;
            end else if (sel_write) begin
                mem[idx] <= sel_wdata;
                if (wr_cnt != {CNT_W{1'b1}}) wr_cnt <= wr_cnt + 1'b1;
            end else begin
                rsp_rdata <= mem[idx];
                if (rd_cnt != {CNT_W{1'b1}}) rd_cnt <= rd_cnt + 1'b1;
            end
        end else if (rsp_valid && rsp_ready) begin
            // Drain with nothing to replace it.
            rsp_valid <= 1'b0;
        end
    end

endmodule
